mdd_param: RTL and testbench
============================

Name: mdd_param

Overview:
Parametrised successor to the nRISC data memory (MDD). It adds configurable data width, address width, depth and read latency to the load/store port used by the datapath. It also adds:
- a reset-time zeroing sequence,
- a ready/valid handshake,
- out-of-range address detection.

It sits on the processor's memory stage. Stores use rt as write_data. Loads return mem_data to the writeback mux.

Parameters:
DATA_W, 8, width of each memory word and of write_data/mem_data
ADDR_W, 8, width of address (immediate + rs)
DEPTH, 256, number of implemented words; legal range 1..2**ADDR_W
RD_LAT, 1, cycles from accepted read to mem_valid; legal range 1..4

Ports:
clock  in  1  single system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
address  in  ADDR_W  word address for read or write
write_data  in  DATA_W  store data
mem_write  in  1  write request, sampled when ready=1
mem_read  in  1  read request, sampled when ready=1
ready  out  1  high when requests are accepted (state SERVE)
mem_data  out  DATA_W  read data, meaningful when mem_valid=1
mem_valid  out  1  one-cycle pulse per accepted read, RD_LAT cycles after acceptance
addr_error  out  1  one-cycle pulse, RD_LAT cycles after an accepted out-of-range access

Behaviour:
Reset:
- reset=1 at a rising edge puts the FSM in INIT and sets init_cnt=0.
- All outputs go to 0: ready=0, mem_data=0, mem_valid=0, addr_error=0.
- The read pipeline is flushed; in-flight reads are discarded and never produce mem_valid.
- Reset asserted mid-operation behaves identically: the memory is re-zeroed.

State INIT:
- Each cycle writes 0 to word init_cnt and increments init_cnt.
- After word DEPTH-1 is written, the next state is SERVE.
- INIT lasts exactly DEPTH cycles after reset deasserts.
- ready=0; mem_read and mem_write are ignored.

State SERVE:
- ready=1.
- Stays in SERVE until reset.

Accepted write (ready=1, mem_write=1, address<DEPTH):
- mem[address] <= write_data at that edge.

Accepted read (ready=1, mem_read=1):
- Data is captured from the array at the acceptance edge.
- It travels an RD_LAT-stage pipeline; mem_valid=1 with that data exactly RD_LAT cycles later.
- Later writes to the same address do not alter data already in flight.

Simultaneous mem_read and mem_write:
- If addresses match, the read returns the new write_data (write-first bypass).
- The write completes normally.

Out-of-range (address>=DEPTH, only when DEPTH<2**ADDR_W):
- Write is dropped; the array is unchanged.
- Read returns mem_data=0 with mem_valid=1.
- addr_error pulses aligned with the pipeline, i.e. RD_LAT cycles after acceptance, for both reads and writes.

Other output rules:
- Back-to-back reads: one read accepted per cycle, results in order, no bubbles.
- mem_data holds its last value while mem_valid=0.
- mem_valid is never high without a prior accepted read.
- Neither request set: no array change, no pulses.

Widths:
- Addresses are compared unsigned at ADDR_W bits.
- init_cnt is clog2(DEPTH)+1 bits so it does not wrap before terminal detection.

Decomposition:
- Shared package mdd_pkg holds:
  - the FSM state typedef (INIT, SERVE);
  - default constants DATA_W_DEF=8, ADDR_W_DEF=8;
  - RD_LAT_MAX=4.
- One sub-module, mdd_rd_pipe. It is a parametrised RD_LAT-deep shift pipeline carrying {valid, error, data}, with synchronous flush on reset.
- The array, INIT counter, FSM and bypass stay in mdd_param.

Test Plan:
1. Reset for 2 cycles, DEPTH=256 -> ready=0 for exactly 256 cycles after reset falls, then 1. Read 0x00, 0x7F and 0xFF -> mem_data=0x00 with mem_valid after RD_LAT.
2. RD_LAT=1: write 0x05 to 0x01, next cycle read 0x01 -> one cycle later mem_valid=1, mem_data=0x05. Write 0x0A to 0x02 during the read -> read result still 0x05.
3. Same cycle mem_write=1, mem_read=1, address=0x10, write_data=0xA5 -> mem_data=0xA5 after RD_LAT. A follow-up read of 0x10 -> 0xA5.
4. DEPTH=200: write 0x33 to 0xC8 -> addr_error pulses RD_LAT cycles later. Read 0xC8 -> mem_data=0x00, mem_valid=1, addr_error=1. Read 0xC7 -> 0x00, addr_error=0.
5. RD_LAT=3: preload 0x01=0x11, 0x02=0x22, 0x03=0x33. Reads on three consecutive cycles -> mem_valid high for three consecutive cycles starting 3 cycles after the first read, data 0x11, 0x22, 0x33 in order.
6. RD_LAT=2: write 0x05 to 0x01, issue read 0x01, assert reset next cycle -> mem_valid never pulses and ready drops. After INIT completes, read 0x01 -> 0x00.

Source files
------------

// File: rtl/mdd_pkg.sv
// Shared types and constants for the parametrised data memory.
// Imported by the top and its read pipeline.
package mdd_pkg;

  typedef enum logic {
    INIT,
    SERVE
  } mdd_state_e;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/mdd_rd_pipe.sv
// Fixed-depth read return pipeline carrying {valid, error, data}.
// Data stages only load on a valid beat so the output holds between reads.
module mdd_rd_pipe
  import mdd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LAT    = 1
) (
  input  logic              clk_i,
  input  logic              flush_i,
  input  logic              vld_i,
  input  logic              err_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic              vld_o,
  output logic              err_o,
  output logic [DATA_W-1:0] dat_o
);

  if (LAT < 1 || LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("mdd_rd_pipe: LAT out of range");
  end

  logic [LAT-1:0]    vld_q;
  logic [LAT-1:0]    err_q;
  logic [DATA_W-1:0] dat_q [LAT];

  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= vld_i;
      err_q[0] <= err_i;
      if (vld_i) dat_q[0] <= dat_i;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[LAT-1];
  assign err_o = err_q[LAT-1];
  assign dat_o = dat_q[LAT-1];

endmodule

// File: rtl/mdd_param.sv
// Parametrised data memory with reset-time zeroing, ready handshake,
// write-first bypass and out-of-range detection.
module mdd_param
  import mdd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mem_write,
  input  logic              mem_read,
  output logic              ready,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_valid,
  output logic              addr_error
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
  localparam logic [CW-1:0]   LAST_C  = CW'(DEPTH - 1);

  mdd_state_e        state_q, state_d;
  logic [CW-1:0]     init_cnt_q, init_cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              in_range;
  logic              rd_acc, wr_acc;
  logic              wr_en;
  logic [IW-1:0]     idx, wr_idx;
  logic [DATA_W-1:0] wr_dat, rd_dat;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_C) state_d = SERVE;
      end
      SERVE: state_d = SERVE;
    endcase
  end

  always_comb begin
    ready = (state_q == SERVE);
  end

  assign idx      = address[IW-1:0];
  assign in_range = {1'b0, address} < DEPTH_A;
  assign rd_acc   = ready & mem_read;
  assign wr_acc   = ready & mem_write;

  // INIT owns the write port; in SERVE only in-range stores reach it
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = init_cnt_q[IW-1:0];
    wr_dat = '0;
    if (state_q == INIT) begin
      wr_en = 1'b1;
    end else if (wr_acc && in_range && !reset) begin
      wr_en  = 1'b1;
      wr_idx = idx;
      wr_dat = write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_idx] <= wr_dat;
  end

  always_comb begin
    rd_dat = '0;
    if (in_range) rd_dat = wr_acc ? write_data : mem_q[idx];
  end

  mdd_rd_pipe #(
    .DATA_W (DATA_W),
    .LAT    (RD_LAT)
  ) u_rd_pipe (
    .clk_i   (clock),
    .flush_i (reset),
    .vld_i   (rd_acc),
    .err_i   ((rd_acc | wr_acc) & ~in_range),
    .dat_i   (rd_dat),
    .vld_o   (mem_valid),
    .err_o   (addr_error),
    .dat_o   (mem_data)
  );

endmodule

// File: tb/tb_mdd_param.sv
// Bench: three memory configurations share one stimulus stream and
// are each checked every cycle against a cycle-indexed reference model.
module tb_mdd_param;

  localparam int N  = 3;
  localparam int D0 = 256;
  localparam int L0 = 1;
  localparam int D1 = 200;
  localparam int L1 = 3;
  localparam int D2 = 16;
  localparam int L2 = 2;

  int dep [N] = '{D0, D1, D2};
  int lat [N] = '{L0, L1, L2};

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] address = '0;
  logic [7:0] write_data = '0;
  logic       mem_write = 1'b0;
  logic       mem_read = 1'b0;

  logic [N-1:0] rdy, mv, ae;
  logic [7:0]   md [N];

  always #5 clock = ~clock;

  mdd_param #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(D0), .RD_LAT(L0)
  ) u0 (
    .clock(clock), .reset(reset), .address(address),
    .write_data(write_data), .mem_write(mem_write),
    .mem_read(mem_read), .ready(rdy[0]), .mem_data(md[0]),
    .mem_valid(mv[0]), .addr_error(ae[0])
  );

  mdd_param #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(D1), .RD_LAT(L1)
  ) u1 (
    .clock(clock), .reset(reset), .address(address),
    .write_data(write_data), .mem_write(mem_write),
    .mem_read(mem_read), .ready(rdy[1]), .mem_data(md[1]),
    .mem_valid(mv[1]), .addr_error(ae[1])
  );

  mdd_param #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(D2), .RD_LAT(L2)
  ) u2 (
    .clock(clock), .reset(reset), .address(address),
    .write_data(write_data), .mem_write(mem_write),
    .mem_read(mem_read), .ready(rdy[2]), .mem_data(md[2]),
    .mem_valid(mv[2]), .addr_error(ae[2])
  );

  // reference state: memory image, cycles since reset, output schedule
  logic [7:0] mm   [N][256];
  int         since[N];
  logic       sv   [N][8];
  logic       se   [N][8];
  logic [7:0] sd   [N][8];
  logic [7:0] hold [N];
  int         edge_n = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(string tag, int k, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d edge%0d got %h want %h",
             tag, k, edge_n, obs, exp);
    end
  endtask

  task automatic step();
    int         s, w;
    logic       inr, ev, ee;
    logic [7:0] ed;
    @(posedge clock);
    #1;
    edge_n++;
    for (int k = 0; k < N; k++) begin
      if (reset) begin
        since[k] = 0;
        hold[k]  = '0;
        for (int j = 0; j < 8; j++) begin
          sv[k][j] = 1'b0;
          se[k][j] = 1'b0;
          sd[k][j] = '0;
        end
        for (int a = 0; a < 256; a++) mm[k][a] = '0;
      end else begin
        if (since[k] >= dep[k]) begin
          inr = int'(address) < dep[k];
          w   = (edge_n + lat[k] - 1) % 8;
          if (mem_read) begin
            sv[k][w] = 1'b1;
            if (!inr) sd[k][w] = '0;
            else if (mem_write) sd[k][w] = write_data;
            else sd[k][w] = mm[k][address];
          end
          if ((mem_read || mem_write) && !inr) se[k][w] = 1'b1;
          if (mem_write && inr) mm[k][address] = write_data;
        end
        if (since[k] < 100000) since[k]++;
      end
      s  = edge_n % 8;
      ev = sv[k][s];
      ee = se[k][s];
      ed = sd[k][s];
      sv[k][s] = 1'b0;
      se[k][s] = 1'b0;
      sd[k][s] = '0;
      if (ev) hold[k] = ed;
      chk("ready", k, 8'(rdy[k]), 8'(since[k] >= dep[k]));
      chk("mem_valid", k, 8'(mv[k]), 8'(ev));
      chk("addr_error", k, 8'(ae[k]), 8'(ee));
      chk("mem_data", k, md[k], hold[k]);
    end
  endtask

  task automatic drv(logic w, logic r, logic [7:0] a, logic [7:0] d);
    mem_write  = w;
    mem_read   = r;
    address    = a;
    write_data = d;
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      since[k] = 0;
      hold[k]  = '0;
      for (int j = 0; j < 8; j++) begin
        sv[k][j] = 1'b0;
        se[k][j] = 1'b0;
        sd[k][j] = '0;
      end
    end

    // reset then zeroing sequence
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(256);
    drv(1'b0, 1'b1, 8'h00, 8'h00);
    drv(1'b0, 1'b1, 8'h7F, 8'h00);
    drv(1'b0, 1'b1, 8'hFF, 8'h00);
    idle(5);

    // store then load; later store must not touch in-flight data
    drv(1'b1, 1'b0, 8'h01, 8'h05);
    drv(1'b0, 1'b1, 8'h01, 8'h00);
    drv(1'b1, 1'b0, 8'h01, 8'h0A);
    drv(1'b1, 1'b0, 8'h02, 8'h0A);
    idle(4);
    drv(1'b0, 1'b1, 8'h01, 8'h00);
    idle(4);

    // write-first bypass
    drv(1'b1, 1'b1, 8'h10, 8'hA5);
    drv(1'b0, 1'b1, 8'h10, 8'h00);
    idle(4);

    // range boundary
    drv(1'b1, 1'b0, 8'hC8, 8'h33);
    drv(1'b0, 1'b1, 8'hC8, 8'h00);
    drv(1'b0, 1'b1, 8'hC7, 8'h00);
    drv(1'b0, 1'b1, 8'h0F, 8'h00);
    drv(1'b0, 1'b1, 8'h10, 8'h00);
    idle(5);

    // back-to-back reads
    drv(1'b1, 1'b0, 8'h01, 8'h11);
    drv(1'b1, 1'b0, 8'h02, 8'h22);
    drv(1'b1, 1'b0, 8'h03, 8'h33);
    drv(1'b0, 1'b1, 8'h01, 8'h00);
    drv(1'b0, 1'b1, 8'h02, 8'h00);
    drv(1'b0, 1'b1, 8'h03, 8'h00);
    idle(5);

    // reset while reads are in flight
    drv(1'b1, 1'b0, 8'h01, 8'h05);
    drv(1'b0, 1'b1, 8'h01, 8'h00);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(256);
    drv(1'b0, 1'b1, 8'h01, 8'h00);
    idle(5);

    // random traffic, one reset pulse in the middle
    for (int i = 0; i < 600; i++) begin
      reset = (i == 250);
      drv(($urandom_range(2) == 0),
          $urandom_range(1) == 1,
          ($urandom_range(3) == 0) ? 8'($urandom)
                                   : 8'($urandom_range(23)),
          8'($urandom));
    end
    reset = 1'b0;
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
